// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the LC-3b memory stage.
// Eight 128-bit lines with 9-bit tags; whole-line fill/evict over a request/response pmem port.
module l1_dcache (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned TAG_W   = 9;
  localparam int unsigned INDEX_W = 3;
  localparam int unsigned LINE_W  = 128;
  localparam int unsigned LINES   = 8;

  typedef logic [TAG_W-1:0]   lc3b_c_tag;
  typedef logic [INDEX_W-1:0] lc3b_c_index;
  typedef logic [LINE_W-1:0]  lc3b_line;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_e;

  state_e state, state_next;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  lc3b_c_tag        tag_arr  [LINES];
  lc3b_line         data_arr [LINES];

  lc3b_c_tag   addr_tag;
  lc3b_c_index index;
  logic [2:0]  word;
  logic [6:0]  bit_base;
  logic        addr_unused;
  logic        request;
  logic        hit;
  logic        do_write;
  logic        do_fill;
  logic        clr_dirty;
  lc3b_line    line_cur;
  lc3b_line    line_wr;

  assign addr_tag    = mem_address[15:7];
  assign index       = mem_address[6:4];
  assign word        = mem_address[3:1];
  assign bit_base    = {word, 4'b0000};
  assign addr_unused = mem_address[0];
  assign request     = mem_read | mem_write;
  assign line_cur    = data_arr[index];
  assign hit         = valid[index] & (tag_arr[index] == addr_tag);

  assign mem_rdata  = line_cur[bit_base +: 16];
  assign pmem_wdata = line_cur;

  // Byte-merge of CPU write data into the addressed word of the current line.
  always_comb begin
    line_wr = line_cur;
    if (mem_byte_enable[0]) line_wr[bit_base +: 8]                = mem_wdata[7:0];
    if (mem_byte_enable[1]) line_wr[7'(bit_base + 7'd8) +: 8]     = mem_wdata[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {addr_tag, index, 4'b0000};
    do_write     = 1'b0;
    do_fill      = 1'b0;
    clr_dirty    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (request) begin
          if (hit) begin
            mem_resp = 1'b1;
            do_write = mem_write;
          end else if (valid[index] && dirty[index]) begin
            state_next = ST_WRITEBACK;
          end else begin
            state_next = ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[index], index, 4'b0000};
        if (pmem_resp) begin
          clr_dirty  = 1'b1;
          state_next = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          do_fill    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Line status bits are the only array state cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (do_fill) begin
        valid[index] <= 1'b1;
        dirty[index] <= 1'b0;
      end
      if (clr_dirty) dirty[index] <= 1'b0;
      if (do_write)  dirty[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_fill) begin
      data_arr[index] <= pmem_rdata;
      tag_arr[index]  <= addr_tag;
    end else if (do_write) begin
      data_arr[index] <= line_wr;
    end
  end

endmodule
